// File: rtl/strobe_period_monitor_pkg.sv
// Shared analyzer package for the strobe period monitor.
// Holds the FSM state encoding, the fault counter width and a saturating
// increment helper for that counter.
package strobe_period_monitor_pkg;

  localparam int unsigned FAULT_CNT_W = 8;

  // Legacy-compatible numeric encodings, reused as the enum values below.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ACQUIRE = ST_ACQUIRE,
    LOCKED  = ST_LOCKED,
    FAULT   = ST_FAULT
  } state_t;

  function automatic logic [FAULT_CNT_W-1:0] fault_sat_inc(input logic [FAULT_CNT_W-1:0] v);
    return (v == '1) ? v : v + FAULT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/strobe_period_monitor.sv
// Strobe period monitor.
// Measures the spacing between one-cycle strobes, locks when the spacing is
// within EXPECTED_PERIOD +/- TOLERANCE, flags early strobes and missing ones.
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset (wins over a same-cycle strobe)
//   strobe       one-cycle pulse under test
//   period       last measured strobe spacing in clk cycles
//   period_valid one-cycle pulse when period updates
//   locked       high while the monitor is locked
//   early        one-cycle pulse: spacing below the tolerance window
//   missed       one-cycle pulse: no strobe within the window's upper bound
//   fault_count  saturating count of early plus missed events
module strobe_period_monitor
  import strobe_period_monitor_pkg::*;
#(
  parameter int unsigned EXPECTED_PERIOD = 24000000,
  parameter int unsigned TOLERANCE       = 16,
  localparam int unsigned CNT_W          = $clog2(EXPECTED_PERIOD + TOLERANCE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   strobe,
  output logic [CNT_W-1:0]       period,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   early,
  output logic                   missed,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(EXPECTED_PERIOD + TOLERANCE);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      early        <= 1'b0;
      missed       <= 1'b0;
      fault_count  <= '0;
    end else begin
      period_valid <= 1'b0;
      early        <= 1'b0;
      missed       <= 1'b0;

      // cnt==P on the cycle of a strobe that arrives P cycles after the last.
      if (strobe)
        cnt <= CNT_W'(1);
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (strobe)
            state <= ACQUIRE;
        end
        default: begin
          // The timeout at WIN_HI leaves this branch before cnt can exceed
          // the window, so late spacings surface only as missed.
          if (strobe) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (cnt < WIN_LO) begin
              state       <= FAULT;
              early       <= 1'b1;
              fault_count <= fault_sat_inc(fault_count);
            end else begin
              state <= LOCKED;
            end
          end else if (cnt == WIN_HI) begin
            state       <= IDLE;
            missed      <= 1'b1;
            fault_count <= fault_sat_inc(fault_count);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/strobe_period_monitor.md
STROBE_PERIOD_MONITOR -- requirements
Module: strobe_period_monitor

Interface
REQ-001 Parameter EXPECTED_PERIOD, default 24000000, nominal strobe spacing in clk cycles.
REQ-002 Parameter TOLERANCE, default 16, allowed deviation in cycles; SHALL satisfy 0 <= TOLERANCE < EXPECTED_PERIOD.
REQ-003 clk  input  1  system clock; sole clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 strobe  input  1  one-cycle pulse under test, synchronous to clk.
REQ-006 period  output  CNT_W  last measured strobe spacing; CNT_W = $clog2(EXPECTED_PERIOD+TOLERANCE+1).
REQ-007 period_valid  output  1  one-cycle pulse when period updates.
REQ-008 locked  output  1  high while the state is LOCKED.
REQ-009 early  output  1  one-cycle pulse: measured spacing < EXPECTED_PERIOD-TOLERANCE.
REQ-010 missed  output  1  one-cycle pulse: no strobe within EXPECTED_PERIOD+TOLERANCE cycles.
REQ-011 fault_count  output  8  saturating count of early plus missed events.

Function
REQ-012 Cycle counter cnt: on a strobe cycle it loads 1, otherwise it increments, saturating at all-ones; spacing P between strobes at cycles t and t+P is read as cnt==P at cycle t+P.
REQ-013 States are IDLE, ACQUIRE, LOCKED and FAULT; locked = (state==LOCKED).
REQ-014 IDLE: on strobe -> ACQUIRE; no period_valid, early or missed.
REQ-015 In ACQUIRE, LOCKED or FAULT, a strobe is a measurement: period <= cnt, and period_valid pulses in the next cycle.
REQ-016 Measurement in window [EXPECTED_PERIOD-TOLERANCE, EXPECTED_PERIOD+TOLERANCE] -> LOCKED; below the window -> FAULT, with early pulsing in the same cycle as period_valid.
REQ-017 Timeout: in ACQUIRE, LOCKED or FAULT, if there is no strobe and cnt==EXPECTED_PERIOD+TOLERANCE, then missed pulses next cycle, state -> IDLE, and period is unchanged.
REQ-018 Late spacings SHALL be reported only via missed; no period_valid SHALL be issued for a spacing greater than EXPECTED_PERIOD+TOLERANCE.
REQ-019 Strobe on consecutive cycles yields period=1 and early (if 1 < EXPECTED_PERIOD-TOLERANCE).
REQ-020 fault_count increments by 1 on each early or missed pulse and holds at 255.
REQ-021 All outputs are registered; latency is 1 cycle from the strobe or timeout cycle to the output pulse.

Reset
REQ-022 Reset: state=IDLE, cnt=0, period=0, period_valid=0, locked=0, early=0, missed=0, fault_count=0.
REQ-023 reset has priority over a strobe in the same cycle; that strobe is ignored.
REQ-024 Reset mid-measurement discards the partial count; the next strobe only re-enters ACQUIRE.

Structure
REQ-025 State encoding and the fault_count width constant (8) belong in the shared analyzer package; CNT_W is derived locally.
REQ-026 Single module; no sub-module required.

Verification (EXPECTED_PERIOD=10, TOLERANCE=1)
REQ-027 Reset, then strobes at cycles 5, 15 and 25 -> no period_valid at cycle 6; period_valid with period=10 and locked=1 at cycles 16 and 26.
REQ-028 While locked, strobe spacing 9, then 11 -> both accepted, period=9 then 11, locked stays 1; spacing 8 -> period=8, early=1, locked=0, fault_count=1.
REQ-029 Last strobe at cycle t, then none -> missed=1 at t+12, state IDLE; a strobe at t+11 instead -> period=11, locked, no missed.
REQ-030 Strobe on two consecutive cycles after ACQUIRE -> period=1, early=1, FAULT; the next in-window spacing -> LOCKED.
REQ-031 Reset asserted with a strobe in the same cycle, then a strobe 10 cycles later -> no period_valid for either; locked only after a third strobe.
REQ-032 300 consecutive timeouts -> fault_count reaches and holds 255.
